// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite subordinate fronting a word-organised on-chip SRAM.
// Supports byte/half/word lanes, back-to-back pipelined beats and two-cycle ERROR responses.
// Optional build macro AHB_SRAM_WAIT_EN: NONSEQ data phases get WAIT_STATES wait cycles
// before the data cycle. Without it, the wait state and its counter are not built and
// every good phase is zero-wait.
module ahb3lite_sram_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;
  // Byte address width inside the array.
  localparam int unsigned BA_W   = ADDR_W + 2;
  // Offset window handed to this region by the interconnect; bits above it are ignored.
  localparam int unsigned OFF_W  = 16;
  localparam int unsigned CMP_W  = OFF_W + 1;
  localparam logic [CMP_W-1:0] MEM_BYTES = CMP_W'(DEPTH * 4);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_ERR1 = 3'd2,
    S_ERR2 = 3'd3
`ifdef AHB_SRAM_WAIT_EN
    , S_WAIT = 3'd4
`endif
  } state_t;

  state_t              r_state;
  logic                r_hreadyout;
  logic                r_hresp;
  logic [DATA_W-1:0]   r_hrdata;
  logic [BA_W-1:0]     r_addr;
  logic                r_write;
  logic [2:0]          r_size;
  logic                r_seq;
  logic [DATA_W-1:0]   r_mem [DEPTH];
`ifdef AHB_SRAM_WAIT_EN
  logic [2:0]          r_wait_cnt;
  logic [DATA_W-1:0]   w_rd_cur;
`endif

  logic                w_accept;
  logic                w_bad;
  logic                w_commit;
  logic                w_fwd_hit;
  logic [LANES-1:0]    w_be;
  logic [ADDR_W-1:0]   w_new_idx;
  logic [ADDR_W-1:0]   w_cur_idx;
  logic [DATA_W-1:0]   w_rd_new;
  logic                w_unused;

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;

  // Address-phase decode: transfer request and its error classification.
  assign w_accept  = HSEL & HREADY & HTRANS[1];
  assign w_bad     = ({1'b0, HADDR[OFF_W-1:0]} >= MEM_BYTES)
                   | (HSIZE > 3'b010)
                   | ((HSIZE == 3'b001) & HADDR[0])
                   | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));

  assign w_new_idx = HADDR[ADDR_W+1:2];
  assign w_cur_idx = r_addr[ADDR_W+1:2];
  // A write data cycle commits HWDATA at the end of this cycle.
  assign w_commit  = (r_state == S_DATA) & r_write;
  assign w_fwd_hit = w_commit & (w_new_idx == w_cur_idx);

  // Inputs and captured fields with no functional use in this slave.
  assign w_unused  = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:OFF_W], r_seq, 3'(WAIT_STATES)};

  // Byte-lane enables of the beat in its data phase.
  always_comb begin
    w_be = '0;
    case (r_size)
      3'b000:  w_be[r_addr[1:0]] = 1'b1;
      3'b001:  w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      3'b010:  w_be = 4'b1111;
      default: w_be = '0;
    endcase
  end

  // Read word for a newly accepted beat, with the write committing this cycle merged in.
  always_comb begin
    w_rd_new = r_mem[w_new_idx];
    for (int i = 0; i < int'(LANES); i++) begin
      if (w_fwd_hit && w_be[i]) begin
        w_rd_new[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

`ifdef AHB_SRAM_WAIT_EN
  // Read word for a beat leaving the wait state (no write can be committing then).
  assign w_rd_cur = r_mem[w_cur_idx];
`endif

  // SRAM array: byte-lane write in the data cycle, never cleared by reset.
  always_ff @(posedge HCLK) begin
    if (!HRESET && w_commit) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (w_be[i]) begin
          r_mem[w_cur_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Transfer FSM with registered HREADYOUT/HRESP/HRDATA and captured address phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_size      <= '0;
      r_seq       <= 1'b0;
`ifdef AHB_SRAM_WAIT_EN
      r_wait_cnt  <= '0;
`endif
    end else begin
      r_hrdata <= '0;
      case (r_state)
`ifdef AHB_SRAM_WAIT_EN
        S_WAIT: begin
          if (r_wait_cnt <= 3'd1) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= r_write ? '0 : w_rd_cur;
          end else begin
            r_wait_cnt  <= r_wait_cnt - 3'd1;
          end
        end
`endif
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all end with HREADYOUT=1, so a new beat may be accepted.
          if (w_accept) begin
            r_addr  <= HADDR[BA_W-1:0];
            r_write <= HWRITE;
            r_size  <= HSIZE;
            r_seq   <= HTRANS[0];
            if (w_bad) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end
`ifdef AHB_SRAM_WAIT_EN
            else if (!HTRANS[0] && (WAIT_STATES != 0)) begin
              r_state     <= S_WAIT;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
              r_wait_cnt  <= 3'(WAIT_STATES);
            end
`endif
            else begin
              r_state     <= S_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
              r_hrdata    <= HWRITE ? '0 : w_rd_new;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Self-checking bench for ahb3lite_sram_slave: directed scenarios plus randomized
// pipelined traffic compared against a byte-level memory model.
module tb_ahb3lite_sram_slave;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned TB_WAIT = 2;
  localparam int          MAXB    = 64;
  localparam int          TMO     = 500;
`ifdef AHB_SRAM_WAIT_EN
  localparam bit WAIT_ON = 1'b1;
`else
  localparam bit WAIT_ON = 1'b0;
`endif
  localparam int NS_WAIT = WAIT_ON ? int'(TB_WAIT) : 0;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  int n_checks = 0;
  int n_errors = 0;

  // Beat table driven by run_seq
  logic [31:0] b_addr  [MAXB];
  logic        b_write [MAXB];
  logic [2:0]  b_size  [MAXB];
  logic [1:0]  b_trans [MAXB];
  logic [31:0] b_wdata [MAXB];
  // Observed per beat
  int          o_low     [MAXB];
  int          o_low_err [MAXB];
  logic        o_resp    [MAXB];
  logic [31:0] o_rdata   [MAXB];
  // Expected per beat
  int          e_low     [MAXB];
  int          e_low_err [MAXB];
  logic        e_resp    [MAXB];
  logic        e_read    [MAXB];
  logic [31:0] e_rdata   [MAXB];
  int          e_extra;
  logic [31:0] ref_mem [DEPTH];
  int          seq_cycles;
  bit          seq_timeout;

  assign hready = hreadyout;

  ahb3lite_sram_slave #(
    .DEPTH       (DEPTH),
    .ADDR_W      (10),
    .WAIT_STATES (TB_WAIT)
  ) dut (
    .HCLK      (hclk),
    .HRESET    (hreset),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HBURST    (hburst),
    .HPROT     (hprot),
    .HMASTLOCK (hmastlock),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .HRDATA    (hrdata)
  );

  always #5 hclk = ~hclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0;
    hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011; hmastlock = 1'b0;
  endtask

  task automatic set_beat(input int i, input logic [31:0] a, input logic w,
                          input logic [2:0] s, input logic [1:0] t, input logic [31:0] d);
    b_addr[i] = a; b_write[i] = w; b_size[i] = s; b_trans[i] = t; b_wdata[i] = d;
  endtask

  task automatic present(input int i);
    if (i < 0) begin
      hsel = 1'b0; htrans = 2'b00;
    end else begin
      hsel = 1'b1; haddr = b_addr[i]; htrans = b_trans[i]; hwrite = b_write[i];
      hsize = b_size[i]; hburst = 3'b001;
    end
  endtask

  // Drive beats 0..n-1 as a pipelined master would; starts just after a posedge with the bus idle.
  task automatic run_seq(input int n);
    int ai, di, cyc;
    logic rdy;
    ai = 0; di = -1; cyc = 0;
    for (int i = 0; i < n; i++) begin
      o_low[i] = 0; o_low_err[i] = 0; o_resp[i] = 1'bx; o_rdata[i] = 32'hx;
    end
    present(n > 0 ? 0 : -1);
    while ((ai < n || di >= 0) && cyc < TMO) begin
      @(negedge hclk);
      rdy = hreadyout;
      if (di >= 0) begin
        if (rdy !== 1'b1) begin
          o_low[di]++;
          if (hresp) o_low_err[di]++;
        end else begin
          o_resp[di]  = hresp;
          o_rdata[di] = hrdata;
        end
      end
      @(posedge hclk); #1;
      cyc++;
      if (rdy === 1'b1) begin
        if (ai < n) begin di = ai; ai++; end
        else di = -1;
        hwdata = (di >= 0 && b_write[di]) ? b_wdata[di] : 32'h0;
        present(ai < n ? ai : -1);
      end
    end
    seq_cycles  = cyc;
    seq_timeout = (cyc >= TMO);
    idle_bus();
  endtask

  // Reference: applies beats 0..n-1 to ref_mem byte by byte and fills expectations.
  function automatic void model(input int n);
    e_extra = 0;
    for (int i = 0; i < n; i++) begin
      int unsigned off, word, nb, lane;
      bit bad;
      off = b_addr[i] % 32'd65536;
      nb  = 0;
      if (b_size[i] > 3'd2) bad = 1'b1;
      else begin
        nb  = 32'd1 << b_size[i];
        bad = (off >= DEPTH * 4) || ((off % nb) != 0);
      end
      word         = off / 4;
      e_resp[i]    = bad;
      e_low_err[i] = bad ? 1 : 0;
      e_low[i]     = bad ? 1 : ((b_trans[i] == 2'b10) ? NS_WAIT : 0);
      e_read[i]    = !bad && !b_write[i];
      e_rdata[i]   = 32'h0;
      e_extra      += e_low[i];
      if (!bad) begin
        if (b_write[i]) begin
          for (int unsigned k = 0; k < nb; k++) begin
            lane = (off % 4) + k;
            ref_mem[word][8*lane +: 8] = b_wdata[i][8*lane +: 8];
          end
        end else begin
          e_rdata[i] = ref_mem[word];
        end
      end
    end
  endfunction

  task automatic test_reset();
    idle_bus(); hwdata = 32'h0; hreset = 1'b1;
    repeat (3) @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(negedge hclk);
    n_checks++;
    if (hreadyout !== 1'b1) begin n_errors++; $display("FAIL reset_hreadyout got %b expected 1", hreadyout); end
    n_checks++;
    if (hresp !== 1'b0) begin n_errors++; $display("FAIL reset_hresp got %b expected 0", hresp); end
    n_checks++;
    if (hrdata !== 32'h0) begin n_errors++; $display("FAIL reset_hrdata got %h expected 00000000", hrdata); end
    @(posedge hclk); #1;
  endtask

  // T1: word write then word read of the same location on consecutive beats.
  task automatic test_word_rw();
    set_beat(0, 32'h0000_0010, 1'b1, 3'b010, 2'b10, 32'hDEADBEEF);
    set_beat(1, 32'h0000_0010, 1'b0, 3'b010, 2'b10, 32'h0);
    run_seq(2);
    model(2);
    n_checks++;
    if (o_rdata[1] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL word_rw_data got %h expected deadbeef", o_rdata[1]); end
    n_checks++;
    if (o_resp[0] !== 1'b0 || o_resp[1] !== 1'b0) begin
      n_errors++; $display("FAIL word_rw_resp got %b%b expected 00", o_resp[0], o_resp[1]);
    end
    n_checks++;
    if (o_low[0] !== NS_WAIT || o_low[1] !== NS_WAIT) begin
      n_errors++; $display("FAIL word_rw_waits got %0d/%0d expected %0d/%0d", o_low[0], o_low[1], NS_WAIT, NS_WAIT);
    end
  endtask

  // T2: byte and half writes land on the right lanes of a cleared word.
  task automatic test_lanes();
    set_beat(0, 32'h0000_0010, 1'b1, 3'b010, 2'b10, 32'h0000_0000);
    set_beat(1, 32'h0000_0011, 1'b1, 3'b000, 2'b10, 32'h0000_AA00);
    set_beat(2, 32'h0000_0012, 1'b1, 3'b001, 2'b10, 32'h5566_0000);
    set_beat(3, 32'h0000_0010, 1'b0, 3'b010, 2'b10, 32'h0);
    run_seq(4);
    model(4);
    n_checks++;
    if (o_rdata[3] !== 32'h5566AA00) begin n_errors++; $display("FAIL lanes_data got %h expected 5566aa00", o_rdata[3]); end
    n_checks++;
    if (e_rdata[3] !== o_rdata[3]) begin n_errors++; $display("FAIL lanes_model got %h expected %h", o_rdata[3], e_rdata[3]); end
  endtask

  // T3/T5: INCR4 write then WRAP4 read starting mid-block.
  task automatic test_wrap_burst();
    logic [31:0] wd [4];
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      set_beat(i, 32'h20 + 32'(4 * i), 1'b1, 3'b010, (i == 0) ? 2'b10 : 2'b11, wd[i]);
    end
    run_seq(4);
    model(4);
    n_checks++;
    if (seq_timeout || seq_cycles !== 5 + e_extra) begin
      n_errors++; $display("FAIL incr4_cycles got %0d expected %0d", seq_cycles, 5 + e_extra);
    end
    for (int i = 0; i < 4; i++) begin
      set_beat(i, 32'h20 + 32'(((i + 2) % 4) * 4), 1'b0, 3'b010, (i == 0) ? 2'b10 : 2'b11, 32'h0);
    end
    run_seq(4);
    model(4);
    n_checks++;
    if (seq_timeout || seq_cycles !== 5 + NS_WAIT) begin
      n_errors++; $display("FAIL wrap4_cycles got %0d expected %0d", seq_cycles, 5 + NS_WAIT);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (o_rdata[i] !== wd[(i + 2) % 4] || o_resp[i] !== 1'b0 || o_low[i] !== e_low[i]) begin
        n_errors++;
        $display("FAIL wrap4_beat%0d got data=%h resp=%b low=%0d expected data=%h resp=0 low=%0d",
                 i, o_rdata[i], o_resp[i], o_low[i], wd[(i + 2) % 4], e_low[i]);
      end
    end
  endtask

  // T4: misaligned, out-of-range and bad-size beats give two-cycle ERROR and write nothing.
  task automatic test_error();
    set_beat(0, 32'h0000_1002, 1'b0, 3'b010, 2'b10, 32'h0);
    set_beat(1, 32'h0000_1000, 1'b0, 3'b010, 2'b10, 32'h0);
    set_beat(2, 32'h0000_0012, 1'b1, 3'b010, 2'b10, 32'hFFFF_FFFF);
    set_beat(3, 32'h0000_0011, 1'b1, 3'b001, 2'b10, 32'hFFFF_FFFF);
    set_beat(4, 32'h0000_0010, 1'b1, 3'b011, 2'b10, 32'hFFFF_FFFF);
    set_beat(5, 32'h0000_0010, 1'b0, 3'b010, 2'b10, 32'h0);
    run_seq(6);
    model(6);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (o_low[i] !== 1 || o_low_err[i] !== 1 || o_resp[i] !== 1'b1) begin
        n_errors++;
        $display("FAIL error_beat%0d got low=%0d low_err=%0d resp=%b expected low=1 low_err=1 resp=1",
                 i, o_low[i], o_low_err[i], o_resp[i]);
      end
    end
    n_checks++;
    if (o_rdata[5] !== 32'h5566AA00 || o_resp[5] !== 1'b0) begin
      n_errors++; $display("FAIL error_mem got %h/%b expected 5566aa00/0", o_rdata[5], o_resp[5]);
    end
    n_checks++;
    if (seq_timeout || seq_cycles !== 7 + 5 + NS_WAIT) begin
      n_errors++; $display("FAIL error_cycles got %0d expected %0d", seq_cycles, 7 + 5 + NS_WAIT);
    end
  endtask

  // Alternating writes and reads of one word exercise read-after-write on consecutive beats.
  task automatic test_back_to_back();
    set_beat(0, 32'h0000_0080, 1'b1, 3'b010, 2'b10, $urandom);
    set_beat(1, 32'h0000_0080, 1'b0, 3'b010, 2'b11, 32'h0);
    set_beat(2, 32'h0000_0081, 1'b1, 3'b000, 2'b11, $urandom);
    set_beat(3, 32'h0000_0080, 1'b0, 3'b010, 2'b11, 32'h0);
    set_beat(4, 32'h0000_0082, 1'b1, 3'b001, 2'b11, $urandom);
    set_beat(5, 32'h0000_0080, 1'b0, 3'b010, 2'b11, 32'h0);
    set_beat(6, 32'h0000_0083, 1'b1, 3'b000, 2'b11, $urandom);
    set_beat(7, 32'h0000_0080, 1'b0, 3'b010, 2'b11, 32'h0);
    run_seq(8);
    model(8);
    n_checks++;
    if (seq_timeout || seq_cycles !== 9 + e_extra) begin
      n_errors++; $display("FAIL b2b_cycles got %0d expected %0d", seq_cycles, 9 + e_extra);
    end
    for (int i = 1; i < 8; i += 2) begin
      n_checks++;
      if (o_rdata[i] !== e_rdata[i] || o_resp[i] !== 1'b0) begin
        n_errors++; $display("FAIL b2b_read%0d got %h/%b expected %h/0", i, o_rdata[i], o_resp[i], e_rdata[i]);
      end
    end
  endtask

  // T6: reset during ERR1 and during the data/wait phase of a write.
  task automatic test_reset_mid();
    set_beat(0, 32'h0000_0040, 1'b1, 3'b010, 2'b10, 32'h1234_5678);
    run_seq(1);
    model(1);
    // Misaligned write -> ERR1, then reset
    hsel = 1'b1; haddr = 32'h0000_0042; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    idle_bus(); hwdata = 32'hFFFF_FFFF; hreset = 1'b1;
    @(negedge hclk);
    n_checks++;
    if (hreadyout !== 1'b0 || hresp !== 1'b1) begin
      n_errors++; $display("FAIL err1_entry got %b/%b expected 0/1", hreadyout, hresp);
    end
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    n_checks++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
      n_errors++; $display("FAIL reset_in_err1 got %b/%b expected 1/0", hreadyout, hresp);
    end
    @(posedge hclk); #1;
    // Good write, reset in its data or wait phase
    hsel = 1'b1; haddr = 32'h0000_0040; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    idle_bus(); hwdata = 32'hCAFE_F00D; hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0; hwdata = 32'h0;
    @(negedge hclk);
    n_checks++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
      n_errors++; $display("FAIL reset_in_write got %b/%b/%h expected 1/0/00000000", hreadyout, hresp, hrdata);
    end
    @(posedge hclk); #1;
    set_beat(0, 32'h0000_0040, 1'b0, 3'b010, 2'b10, 32'h0);
    run_seq(1);
    model(1);
    n_checks++;
    if (o_rdata[0] !== 32'h1234_5678 || e_rdata[0] !== 32'h1234_5678) begin
      n_errors++; $display("FAIL reset_no_commit got %h expected 12345678", o_rdata[0]);
    end
  endtask

  // Random mixed traffic in a 128-byte region with occasional error beats and idle gaps.
  task automatic test_random();
    int n, sz, kind, gaps;
    logic [31:0] a;
    for (int i = 0; i < 32; i++) begin
      set_beat(i, 32'h100 + 32'(4 * i), 1'b1, 3'b010, (i == 0) ? 2'b10 : 2'b11, $urandom);
    end
    run_seq(32);
    model(32);
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(4, 24);
      for (int i = 0; i < n; i++) begin
        sz   = $urandom_range(0, 2);
        a    = 32'h100 + (32'($urandom_range(0, 127)) & ~((32'd1 << sz) - 32'd1));
        kind = $urandom_range(0, 11);
        if (kind == 0) sz = 3;
        else if (kind == 1) a = 32'h1000 + (32'($urandom_range(0, 255)) & ~32'd3);
        else if (kind == 2) begin sz = 2; a = a | 32'd1; end
        a[31:16] = 16'($urandom);
        set_beat(i, a, 1'($urandom_range(0, 1)), 3'(sz),
                 (i == 0 || $urandom_range(0, 2) == 0) ? 2'b10 : 2'b11, $urandom);
      end
      run_seq(n);
      model(n);
      n_checks++;
      if (seq_timeout || seq_cycles !== n + 1 + e_extra) begin
        n_errors++; $display("FAIL rnd%0d_cycles got %0d expected %0d", r, seq_cycles, n + 1 + e_extra);
      end
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (o_low[i] !== e_low[i] || o_low_err[i] !== e_low_err[i] || o_resp[i] !== e_resp[i] ||
            (e_read[i] && o_rdata[i] !== e_rdata[i])) begin
          n_errors++;
          $display("FAIL rnd%0d_beat%0d addr=%h got low=%0d/%0d resp=%b data=%h expected low=%0d/%0d resp=%b data=%h",
                   r, i, b_addr[i], o_low[i], o_low_err[i], o_resp[i], o_rdata[i],
                   e_low[i], e_low_err[i], e_resp[i], e_rdata[i]);
        end
      end
      // Unselected NONSEQ writes and selected BUSY must not start a data phase.
      gaps = $urandom_range(1, 3);
      for (int g = 0; g < gaps; g++) begin
        hsel = 1'($urandom_range(0, 1));
        htrans = hsel ? 2'b01 : 2'b10;
        haddr = 32'h100 + (32'($urandom_range(0, 31)) * 4);
        hwrite = 1'b1; hsize = 3'b010; hwdata = $urandom;
        @(negedge hclk);
        n_checks++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
          n_errors++; $display("FAIL rnd%0d_gap got %b/%b/%h expected 1/0/00000000", r, hreadyout, hresp, hrdata);
        end
        @(posedge hclk); #1;
      end
      idle_bus(); hwdata = 32'h0;
    end
  endtask

  initial begin
    idle_bus();
    hwdata = 32'h0;
    hreset = 1'b1;
    test_reset();
    test_word_rw();
    test_lanes();
    test_wrap_burst();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
